io_console_responder: RTL and testbench
=======================================

# io_console_responder

Board-side responder for the CPU's IN/OUT instructions. The CPU core issues a four-phase req/ack transaction: IN returns the board switch value once the operator presses the confirm button; OUT converts a binary word to three BCD digits for the hundreds/tens/units displays. The block owns button synchronisation and debounce, the input-wait state, and a sequential double-dabble converter. It sits between the CPU datapath and the board's switches, button and seven-segment decoders.

## Interface

- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to accept a button level change (≥2).
- SW_W, 8: switch bus width (≤32).
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- req  in  1  CPU request; level, held until ack seen.
- cmd  in  1  0 = IN, 1 = OUT; valid while req=1.
- wdata  in  32  OUT value; valid while req=1.
- btn  in  1  raw confirm button, asynchronous, active-high.
- sw  in  SW_W  raw switches; sampled only at the capture edge.
- ack  out  1  transaction complete; high until req drops.
- busy  out  1  state ≠ IDLE.
- rdata  out  32  IN result, zero-extended sw; holds until next IN completes.
- waiting_input  out  1  high in WAIT_BTN (drives "ledin").
- bcd_hundreds, bcd_tens, bcd_units  out  4 each  displayed digits.
- overflow  out  1  last OUT value exceeded 999.

## Operation

- Button path: 2-flop synchroniser → debounce counter. The counter clears while the synchronised level equals btn_db and increments while it differs. When it reaches DEBOUNCE_CYCLES-1 and the level still differs, btn_db toggles and the counter clears. btn_pulse is a one-cycle pulse on the btn_db rising edge.
- FSM states: IDLE, WAIT_BTN, CONVERT, DONE.
- IDLE, req=1, cmd=0 → WAIT_BTN.
- IDLE, req=1, cmd=1:
  - Latch wdata. If wdata > 999, load 999 and set overflow=1; otherwise load wdata[9:0] and clear overflow.
  - Clear BCD scratch and iteration counter; → CONVERT.
- WAIT_BTN:
  - On btn_pulse: rdata ← {zero, sw}; → DONE.
  - btn_pulse in any other state is discarded, including a press before the IN request.
- CONVERT: 10 iterations, one per cycle.
  - Each iteration adds 3 to every scratch digit ≥5, then shifts {scratch, value} left by 1.
  - After iteration 10, all three bcd_* outputs update on the same edge (no partial digits visible); → DONE.
- DONE: ack=1. Stays while req=1; → IDLE on the first edge with req=0.
- req changes while busy are ignored. cmd and wdata are sampled only at the IDLE acceptance edge.
- Display outputs and overflow change only at CONVERT completion. rdata changes only at IN capture.

## Timing

- Reset values: ack=0, busy=0, waiting_input=0, rdata=0, all bcd_*=0, overflow=0. Internal reset values: btn_db=0, state IDLE, counters 0.
- Reset mid-transaction aborts immediately: the next state is IDLE, no ack is produced, and displays and overflow return to 0.
- OUT latency: acceptance edge E0 (IDLE→CONVERT), iterations on E1–E10, then digits and ack visible after E10. ack therefore rises exactly 10 cycles after acceptance.
- IN latency: ack rises on the edge where state=WAIT_BTN and btn_pulse=1; rdata is valid in the same cycle.
- Debounce: a clean raw rise produces btn_pulse no later than DEBOUNCE_CYCLES+3 cycles after it. A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- Four-phase rule: ack falls one cycle after req is seen low. A new req is accepted no earlier than the edge after return to IDLE.
- waiting_input and busy are registered with the state and carry no combinational paths from inputs.

## Test plan

- Reset: assert reset mid-cycle with random inputs → every output 0 while reset is high; after release, busy=0.
- OUT 237: req=1, cmd=1, wdata=237 → ack rises exactly 10 cycles after acceptance with digits 2/3/7 and overflow=0. Hold req 5 more cycles → ack stays 1. Drop req → ack=0 next cycle, busy=0.
- OUT 1500, then OUT 0 → first transaction gives digits 9/9/9 with overflow=1; second gives 0/0/0 with overflow=0.
- IN with bounce: sw=8'hA5, req with cmd=0 → waiting_input=1 and no ack. Apply three high glitches of 3 cycles each → still no ack. Then hold btn high → ack within DEBOUNCE_CYCLES+3 cycles, rdata=32'h000000A5, waiting_input=0.
- Early press: press and release btn in IDLE, then issue IN → no ack until a fresh press. A press after the request completes the transaction normally.
- Reset mid-CONVERT: OUT 456, assert reset at iteration 5 → digits 0/0/0, ack=0, busy=0. After release, OUT 81 completes with digits 0/8/1.

Source files
------------

// File: rtl/io_console_responder.sv
// Board-side responder for CPU IN/OUT transactions: debounced confirm button,
// switch capture for IN, and a sequential binary-to-BCD converter for OUT.
module io_console_responder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SW_W            = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            cmd,
    input  logic [31:0]     wdata,
    input  logic            btn,
    input  logic [SW_W-1:0] sw,
    output logic            ack,
    output logic            busy,
    output logic [31:0]     rdata,
    output logic            waiting_input,
    output logic [3:0]      bcd_hundreds,
    output logic [3:0]      bcd_tens,
    output logic [3:0]      bcd_units,
    output logic            overflow
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] LAST_ITER = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BTN,
        S_CONVERT,
        S_DONE
    } state_e;

    // Button synchroniser and debounce
    logic             sync1_q, sync2_q;
    logic             btn_db_q, btn_prev_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic             btn_pulse;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_db_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            btn_prev_q <= btn_db_q;
            if (sync2_q == btn_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == CNT_MAX) begin
                btn_db_q <= ~btn_db_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // Decoded from registers only, so it carries no path from the raw pin.
    assign btn_pulse = btn_db_q & ~btn_prev_q;

    // Double-dabble datapath
    state_e      state_q;
    logic [9:0]  value_q, value_d;
    logic [11:0] scratch_q, scratch_d;
    logic [11:0] adj;
    logic [3:0]  iter_q;
    logic        ovf_pend_q;

    logic        ack_q, busy_q, waiting_q, overflow_q;
    logic [31:0] rdata_q;
    logic [3:0]  hund_q, tens_q, units_q;

    // NOTE: adj is fully assigned before any conditional update, so no
    // latch is inferred for the digits that do not need correcting.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        {scratch_d, value_d} = {adj[10:0], value_q, 1'b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            value_q    <= '0;
            scratch_q  <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            waiting_q  <= 1'b0;
            overflow_q <= 1'b0;
            rdata_q    <= '0;
            hund_q     <= '0;
            tens_q     <= '0;
            units_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        busy_q <= 1'b1;
                        if (cmd) begin
                            value_q    <= (wdata > 32'd999) ? 10'd999 : wdata[9:0];
                            ovf_pend_q <= (wdata > 32'd999);
                            scratch_q  <= '0;
                            iter_q     <= '0;
                            state_q    <= S_CONVERT;
                        end else begin
                            waiting_q <= 1'b1;
                            state_q   <= S_WAIT_BTN;
                        end
                    end
                end
                S_WAIT_BTN: begin
                    if (btn_pulse) begin
                        rdata_q   <= 32'(sw);
                        waiting_q <= 1'b0;
                        ack_q     <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_CONVERT: begin
                    scratch_q <= scratch_d;
                    value_q   <= value_d;
                    iter_q    <= iter_q + 4'd1;
                    // Digits and overflow publish together on the final iteration.
                    if (iter_q == LAST_ITER) begin
                        hund_q     <= scratch_d[11:8];
                        tens_q     <= scratch_d[7:4];
                        units_q    <= scratch_d[3:0];
                        overflow_q <= ovf_pend_q;
                        ack_q      <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!req) begin
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    ack_q     <= 1'b0;
                    busy_q    <= 1'b0;
                    waiting_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack           = ack_q;
    assign busy          = busy_q;
    assign waiting_input = waiting_q;
    assign rdata         = rdata_q;
    assign bcd_hundreds  = hund_q;
    assign bcd_tens      = tens_q;
    assign bcd_units     = units_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_io_console_responder.sv
// Directed bench for io_console_responder: OUT conversions, debounced IN,
// early-press rejection and reset aborts, all against hand-computed values.
module tb_io_console_responder;

    localparam int DC   = 16;
    localparam int SW_W = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req, cmd, btn;
    logic [31:0]     wdata;
    logic [SW_W-1:0] sw;
    logic            ack, busy, waiting_input, overflow;
    logic [31:0]     rdata;
    logic [3:0]      bcd_hundreds, bcd_tens, bcd_units;

    int checks = 0;
    int errors = 0;

    io_console_responder #(.DEBOUNCE_CYCLES(DC), .SW_W(SW_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .cmd           (cmd),
        .wdata         (wdata),
        .btn           (btn),
        .sw            (sw),
        .ack           (ack),
        .busy          (busy),
        .rdata         (rdata),
        .waiting_input (waiting_input),
        .bcd_hundreds  (bcd_hundreds),
        .bcd_tens      (bcd_tens),
        .bcd_units     (bcd_units),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // Counts edges until ack rises; 0 means the budget expired.
    task automatic wait_ack(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic end_txn(input string tag);
        @(negedge clk);
        req = 1'b0;
        tick(1);
        chk({tag, " ack_fall"}, 32'(ack), 32'd0);
        chk({tag, " busy_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_out(input string tag, input logic [31:0] v,
                          input logic [3:0] h, input logic [3:0] t,
                          input logic [3:0] u, input logic ov);
        int lat;
        int held;
        @(negedge clk);
        req   = 1'b1;
        cmd   = 1'b1;
        wdata = v;
        @(posedge clk);
        wait_ack(20, lat);
        chk({tag, " latency"}, 32'(lat), 32'd10);
        chk({tag, " digits"}, {20'd0, bcd_hundreds, bcd_tens, bcd_units}, {20'd0, h, t, u});
        chk({tag, " overflow"}, 32'(overflow), 32'(ov));
        held = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (ack === 1'b1) held++;
        end
        chk({tag, " ack_held"}, 32'(held), 32'd5);
        end_txn(tag);
    endtask

    initial begin
        int lat;
        int stray;

        reset = 1'b1;
        req   = 1'b0;
        cmd   = 1'b0;
        btn   = 1'b0;
        wdata = '0;
        sw    = '0;
        tick(3);
        @(negedge clk);
        reset = 1'b0;

        // Random activity, then reset asserted between edges.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req   = 1'($urandom);
            cmd   = 1'($urandom);
            btn   = 1'($urandom);
            wdata = $urandom;
            sw    = SW_W'($urandom);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("reset outputs",
            {20'd0, ack, busy, waiting_input, overflow, bcd_hundreds, bcd_tens, bcd_units} | rdata,
            32'd0);
        req = 1'b0;
        btn = 1'b0;
        tick(2);
        chk("reset held rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        chk("post-reset busy", 32'(busy), 32'd0);
        tick(DC + 4);

        do_out("out237", 32'd237, 4'd2, 4'd3, 4'd7, 1'b0);
        do_out("out1500", 32'd1500, 4'd9, 4'd9, 4'd9, 1'b1);
        do_out("out0", 32'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        do_out("out999", 32'd999, 4'd9, 4'd9, 4'd9, 1'b0);
        do_out("out1000", 32'd1000, 4'd9, 4'd9, 4'd9, 1'b1);

        // IN with a bouncing button.
        @(negedge clk);
        sw  = 8'hA5;
        req = 1'b1;
        cmd = 1'b0;
        tick(1);
        chk("in waiting", 32'(waiting_input), 32'd1);
        chk("in busy", 32'(busy), 32'd1);
        stray = 0;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            btn = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                if (ack === 1'b1) stray++;
            end
            @(negedge clk);
            btn = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick(1);
                if (ack === 1'b1) stray++;
            end
        end
        chk("glitch no ack", 32'(stray), 32'd0);
        chk("glitch still waiting", 32'(waiting_input), 32'd1);
        @(negedge clk);
        btn = 1'b1;
        wait_ack(DC + 3, lat);
        chk("in ack in time", 32'(lat != 0), 32'd1);
        chk("in rdata", rdata, 32'h0000_00A5);
        chk("in waiting cleared", 32'(waiting_input), 32'd0);
        end_txn("in");
        btn = 1'b0;
        sw  = 8'h00;
        tick(DC + 6);
        chk("rdata holds", rdata, 32'h0000_00A5);

        // Press and release before the IN request must be discarded.
        @(negedge clk);
        btn = 1'b1;
        tick(DC + 6);
        @(negedge clk);
        btn = 1'b0;
        tick(DC + 6);
        chk("early press idle", 32'(busy), 32'd0);
        @(negedge clk);
        sw  = 8'h3C;
        req = 1'b1;
        cmd = 1'b0;
        stray = 0;
        for (int i = 0; i < 2 * DC; i++) begin
            tick(1);
            if (ack === 1'b1) stray++;
        end
        chk("early press no ack", 32'(stray), 32'd0);
        @(negedge clk);
        btn = 1'b1;
        wait_ack(DC + 3, lat);
        chk("fresh press ack", 32'(lat != 0), 32'd1);
        chk("fresh press rdata", rdata, 32'h0000_003C);
        end_txn("fresh");
        btn = 1'b0;
        tick(DC + 6);

        // Reset in the middle of converting 456; display shows 9/9/9 overflow.
        @(negedge clk);
        req   = 1'b1;
        cmd   = 1'b1;
        wdata = 32'd456;
        @(posedge clk);
        tick(5);
        chk("no partial digits",
            {23'd0, overflow, bcd_hundreds, bcd_tens, bcd_units}, {23'd0, 1'b1, 12'h999});
        #1 reset = 1'b1;
        #1;
        chk("abort digits",
            {23'd0, overflow, bcd_hundreds, bcd_tens, bcd_units}, 32'd0);
        chk("abort ack busy", {30'd0, ack, busy}, 32'd0);
        req = 1'b0;
        tick(2);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        chk("abort idle", 32'(busy), 32'd0);

        do_out("out81", 32'd81, 4'd0, 4'd8, 4'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
